answer_accumulator: RTL

ANSWER_ACCUMULATOR -- requirements
Module: answer_accumulator

---
 rtl/answer_accumulator_if.sv | 25 ++
 rtl/answer_accumulator.sv | 111 +++++++++++
 2 files changed

// File: rtl/answer_accumulator_if.sv
// Sample/result handshake bundle for answer_accumulator.
// slave = accumulator side, master = producer/consumer side.
interface answer_accumulator_if #(
  parameter int ACC_W = 12
);
  logic [7:0]       i_answer;
  logic             i_mode;
  logic             i_valid;
  logic             o_ready;
  logic             o_valid;
  logic             i_ready;
  logic [ACC_W-1:0] o_sum;
  logic             o_ovf;
  logic             o_mode;

  modport slave (
    input  i_answer, i_mode, i_valid, i_ready,
    output o_ready, o_valid, o_sum, o_ovf, o_mode
  );

  modport master (
    output i_answer, i_mode, i_valid, i_ready,
    input  o_ready, o_valid, o_sum, o_ovf, o_mode
  );
endinterface

// File: rtl/answer_accumulator.sv
// Block accumulator of ACC_LEN 8-bit samples, unsigned or signed.
// Define ACC_SAT_EN to saturate on overflow instead of wrapping.
module answer_accumulator #(
  parameter int ACC_LEN = 4,
  parameter int ACC_W   = 12
) (
  input logic i_clk,
  input logic i_rst,
  answer_accumulator_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_t;

  state_t           state, state_nxt;
  logic [ACC_W-1:0] acc, acc_nxt;
  logic [ACC_W-1:0] ext, sum, added;
  logic [7:0]       count, count_nxt;
  logic             ovf, ovf_nxt;
  logic             mode, mode_nxt;
  logic             sel_mode;
  logic             carry, sovf, add_ovf;

  // First sample of a block uses the incoming mode; later ones the latched mode.
  assign sel_mode = (state == IDLE) ? bus.i_mode : mode;
  assign ext = sel_mode ? ACC_W'($signed(bus.i_answer))
                        : ACC_W'(bus.i_answer);

  assign {carry, sum} = {1'b0, acc} + {1'b0, ext};
  assign sovf = (acc[ACC_W-1] == ext[ACC_W-1]) &&
                (sum[ACC_W-1] != acc[ACC_W-1]);
  assign add_ovf = mode ? sovf : carry;

`ifdef ACC_SAT_EN
  logic [ACC_W-1:0] sat;

  always_comb begin
    sat = '1;
    if (mode) begin
      sat = acc[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                         : {1'b0, {(ACC_W-1){1'b1}}};
    end
  end

  assign added = add_ovf ? sat : sum;
`else
  assign added = sum;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      acc   <= '0;
      count <= '0;
      ovf   <= 1'b0;
      mode  <= 1'b0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      count <= count_nxt;
      ovf   <= ovf_nxt;
      mode  <= mode_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    count_nxt = count;
    ovf_nxt   = ovf;
    mode_nxt  = mode;
    unique case (state)
      IDLE: begin
        if (bus.i_valid) begin
          mode_nxt  = bus.i_mode;
          acc_nxt   = ext;
          count_nxt = 8'd1;
          ovf_nxt   = 1'b0;
          state_nxt = ACCUM;
        end
      end
      ACCUM: begin
        if (bus.i_valid) begin
          acc_nxt   = added;
          count_nxt = count + 8'd1;
          if (add_ovf) ovf_nxt = 1'b1;
          if (count_nxt == 8'(ACC_LEN)) state_nxt = DONE;
        end
      end
      DONE: begin
        if (bus.i_ready) begin
          state_nxt = IDLE;
          acc_nxt   = '0;
          count_nxt = '0;
          ovf_nxt   = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.o_ready = (state != DONE);
  assign bus.o_valid = (state == DONE);
  assign bus.o_sum   = acc;
  assign bus.o_ovf   = ovf;
  assign bus.o_mode  = mode;

endmodule
